// File: rtl/iram_fetch_ctrl.sv
// Brainfuck-style instruction fetcher: reads IRAM, presents ops, resolves '[' ']' internally by scanning.
// Latency: INSN_VALID two cycles after FETCH; holds INSN until INSN_READY; BR_WAIT stalls until CORE_IDLE.
module iram_fetch_ctrl #(
    parameter int IA_WIDTH    = 11,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    output logic [IA_WIDTH-1:0] IA,
    output logic                IEN,
    input  logic [7:0]          IDIN,
    output logic [7:0]          INSN,
    output logic                INSN_VALID,
    input  logic                INSN_READY,
    input  logic                CORE_IDLE,
    input  logic                CELL_ZERO,
    output logic                HALT,
    output logic                ERROR
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        PRESENT,
        BR_WAIT,
        SCAN_FWD_RD,
        SCAN_FWD_DEC,
        SCAN_BK_RD,
        SCAN_BK_DEC,
        HALTED,
        ERR
    } state_t;

    localparam logic [7:0]             OP_END    = 8'h00;
    localparam logic [7:0]             OP_OPEN   = 8'h5B;
    localparam logic [7:0]             OP_CLOSE  = 8'h5D;
    localparam logic [IA_WIDTH-1:0]    PC_ONE    = IA_WIDTH'(1);
    localparam logic [IA_WIDTH-1:0]    PC_MAX    = {IA_WIDTH{1'b1}};
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = {DEPTH_WIDTH{1'b1}};

    state_t                 state;
    logic [IA_WIDTH-1:0]    pc;
    logic [DEPTH_WIDTH-1:0] depth;
    logic [7:0]             insn_q;
    logic                   insn_vld_q;
    logic                   br_open;

    assign IA         = pc;
    assign IEN        = RST_N & ((state == FETCH) | (state == SCAN_FWD_RD) | (state == SCAN_BK_RD));
    assign INSN       = insn_q;
    assign INSN_VALID = insn_vld_q;
    // HALT rises in the DECODE cycle that sees the end byte, then stays via HALTED.
    assign HALT       = (state == HALTED) | ((state == DECODE) & (IDIN == OP_END));
    assign ERROR      = (state == ERR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= FETCH;
            pc         <= '0;
            depth      <= '0;
            insn_q     <= 8'h00;
            insn_vld_q <= 1'b0;
            br_open    <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= DECODE;

                DECODE: begin
                    if (IDIN == OP_END) begin
                        state <= HALTED;
                    end else if ((IDIN == OP_OPEN) || (IDIN == OP_CLOSE)) begin
                        br_open <= (IDIN == OP_OPEN);
                        state   <= BR_WAIT;
                    end else begin
                        insn_q     <= IDIN;
                        insn_vld_q <= 1'b1;
                        state      <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (INSN_READY) begin
                        insn_vld_q <= 1'b0;
                        pc         <= pc + PC_ONE;
                        state      <= FETCH;
                    end
                end

                BR_WAIT: begin
                    if (CORE_IDLE) begin
                        // '[' on non-zero or ']' on zero falls through to the next byte.
                        if (br_open != CELL_ZERO) begin
                            pc    <= pc + PC_ONE;
                            state <= FETCH;
                        end else if (br_open) begin
                            if (pc == PC_MAX) begin
                                state <= ERR;
                            end else begin
                                depth <= DEPTH_ONE;
                                pc    <= pc + PC_ONE;
                                state <= SCAN_FWD_RD;
                            end
                        end else begin
                            if (pc == '0) begin
                                state <= ERR;
                            end else begin
                                depth <= DEPTH_ONE;
                                pc    <= pc - PC_ONE;
                                state <= SCAN_BK_RD;
                            end
                        end
                    end
                end

                SCAN_FWD_RD: state <= SCAN_FWD_DEC;

                SCAN_FWD_DEC: begin
                    if (IDIN == OP_END) begin
                        state <= ERR;
                    end else if ((IDIN == OP_CLOSE) && (depth == DEPTH_ONE)) begin
                        depth <= '0;
                        pc    <= pc + PC_ONE;
                        state <= FETCH;
                    end else if ((IDIN == OP_OPEN) && (depth == DEPTH_MAX)) begin
                        state <= ERR;
                    end else if (pc == PC_MAX) begin
                        state <= ERR;
                    end else begin
                        if (IDIN == OP_OPEN) begin
                            depth <= depth + DEPTH_ONE;
                        end else if (IDIN == OP_CLOSE) begin
                            depth <= depth - DEPTH_ONE;
                        end
                        pc    <= pc + PC_ONE;
                        state <= SCAN_FWD_RD;
                    end
                end

                SCAN_BK_RD: state <= SCAN_BK_DEC;

                SCAN_BK_DEC: begin
                    // Resume just past the matching '[' so it is not re-evaluated.
                    if ((IDIN == OP_OPEN) && (depth == DEPTH_ONE)) begin
                        depth <= '0;
                        pc    <= pc + PC_ONE;
                        state <= FETCH;
                    end else if ((IDIN == OP_CLOSE) && (depth == DEPTH_MAX)) begin
                        state <= ERR;
                    end else if (pc == '0) begin
                        state <= ERR;
                    end else begin
                        if (IDIN == OP_CLOSE) begin
                            depth <= depth + DEPTH_ONE;
                        end else if (IDIN == OP_OPEN) begin
                            depth <= depth - DEPTH_ONE;
                        end
                        pc    <= pc - PC_ONE;
                        state <= SCAN_BK_RD;
                    end
                end

                HALTED: state <= HALTED;
                ERR:    state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_iram_fetch_ctrl.sv
// Directed bench for iram_fetch_ctrl with a behavioural one-cycle-latency IRAM.
module tb_iram_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [10:0] IA;
    logic        IEN;
    logic [7:0]  IDIN;
    logic [7:0]  INSN;
    logic        INSN_VALID;
    logic        INSN_READY;
    logic        CORE_IDLE;
    logic        CELL_ZERO;
    logic        HALT;
    logic        ERROR;

    logic [7:0]  mem [0:2047];
    int          rd_cnt = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    iram_fetch_ctrl #(.IA_WIDTH(11), .DEPTH_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IA         (IA),
        .IEN        (IEN),
        .IDIN       (IDIN),
        .INSN       (INSN),
        .INSN_VALID (INSN_VALID),
        .INSN_READY (INSN_READY),
        .CORE_IDLE  (CORE_IDLE),
        .CELL_ZERO  (CELL_ZERO),
        .HALT       (HALT),
        .ERROR      (ERROR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (IEN) begin
            IDIN   <= mem[IA];
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    // Leaves the bench at cycle 0 (the first FETCH cycle after release).
    task automatic start();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
    endtask

    initial begin
        int vcnt;
        int rd0;
        int guard;

        RST_N      = 1'b0;
        INSN_READY = 1'b1;
        CORE_IDLE  = 1'b1;
        CELL_ZERO  = 1'b0;
        IDIN       = 8'h00;

        // Straight-line program "+>" then end byte
        load("+>");
        next(1);
        chk("rst_ien",   IEN, 0);
        chk("rst_ia",    IA, 0);
        chk("rst_valid", INSN_VALID, 0);
        chk("rst_insn",  INSN, 8'h00);
        chk("rst_halt",  HALT, 0);
        chk("rst_error", ERROR, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("a_c0_ien", IEN, 1);
        chk("a_c0_ia",  IA, 0);
        next(1);
        chk("a_c1_ien",   IEN, 0);
        chk("a_c1_valid", INSN_VALID, 0);
        next(1);
        chk("a_c2_valid", INSN_VALID, 1);
        chk("a_c2_insn",  INSN, 8'h2B);
        next(1);
        chk("a_c3_ia",    IA, 1);
        chk("a_c3_ien",   IEN, 1);
        chk("a_c3_valid", INSN_VALID, 0);
        next(2);
        chk("a_c5_valid", INSN_VALID, 1);
        chk("a_c5_insn",  INSN, 8'h3E);
        next(1);
        chk("a_c6_ia",   IA, 2);
        chk("a_c6_halt", HALT, 0);
        next(1);
        chk("a_c7_halt", HALT, 1);
        next(1);
        chk("a_c8_halt",  HALT, 1);
        chk("a_c8_ien",   IEN, 0);
        chk("a_c8_valid", INSN_VALID, 0);
        chk("a_c8_error", ERROR, 0);

        // Nested forward skip "[+[-]>]."
        load("[+[-]>].");
        CELL_ZERO = 1'b1;
        start();
        rd0  = rd_cnt;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 2) chk("b_brwait_ien", IEN, 0);
            if (INSN_VALID) vcnt++;
            next(1);
        end
        chk("b_c15_ia",    IA, 7);
        chk("b_c15_ien",   IEN, 1);
        chk("b_no_valid",  vcnt, 0);
        chk("b_reads",     rd_cnt - rd0, 7);
        next(2);
        chk("b_c17_valid", INSN_VALID, 1);
        chk("b_c17_insn",  INSN, 8'h2E);
        next(2);
        chk("b_c19_halt",  HALT, 1);

        // Loop back "+[-]"
        load("+[-]");
        CELL_ZERO = 1'b0;
        start();
        next(2);
        chk("c_c2_insn",  INSN, 8'h2B);
        next(6);
        chk("c_c8_valid", INSN_VALID, 1);
        chk("c_c8_insn",  INSN, 8'h2D);
        next(4);
        chk("c_c12_ia",   IA, 2);
        chk("c_c12_ien",  IEN, 1);
        next(2);
        chk("c_c14_ia",   IA, 1);
        next(2);
        chk("c_c16_ia",   IA, 2);
        chk("c_c16_ien",  IEN, 1);
        next(2);
        chk("c_c18_valid", INSN_VALID, 1);
        chk("c_c18_insn",  INSN, 8'h2D);
        CELL_ZERO = 1'b1;
        next(4);
        chk("c_c22_ia",   IA, 4);
        chk("c_c22_ien",  IEN, 1);
        next(1);
        chk("c_c23_halt", HALT, 1);

        // Unterminated forward scan "[+" then end byte
        load("[+");
        CELL_ZERO = 1'b1;
        start();
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (INSN_VALID) vcnt++;
            next(1);
        end
        chk("d_c6_error", ERROR, 0);
        next(1);
        chk("d_c7_error", ERROR, 1);
        chk("d_c7_ien",   IEN, 0);
        for (int i = 0; i < 5; i++) begin
            if (INSN_VALID) vcnt++;
            next(1);
        end
        chk("d_c12_error", ERROR, 1);
        chk("d_no_valid",  vcnt, 0);

        // Unmatched close "+]"
        load("+]");
        CELL_ZERO = 1'b0;
        start();
        next(6);
        chk("d2_c6_ia",    IA, 0);
        chk("d2_c6_ien",   IEN, 1);
        next(1);
        chk("d2_c7_error", ERROR, 0);
        next(1);
        chk("d2_c8_error", ERROR, 1);
        chk("d2_c8_halt",  HALT, 0);

        // Backpressure and BR_WAIT stall "-[."
        load("-[.");
        INSN_READY = 1'b0;
        CORE_IDLE  = 1'b1;
        CELL_ZERO  = 1'b0;
        start();
        next(2);
        for (int i = 0; i < 10; i++) begin
            chk("e_hold_insn",  INSN, 8'h2D);
            chk("e_hold_valid", INSN_VALID, 1);
            chk("e_hold_ia",    IA, 0);
            next(1);
        end
        INSN_READY = 1'b1;
        CORE_IDLE  = 1'b0;
        next(1);
        chk("e_c13_ia",    IA, 1);
        chk("e_c13_valid", INSN_VALID, 0);
        next(2);
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) begin
            chk("e_wait_ien", IEN, 0);
            next(1);
        end
        chk("e_wait_reads", rd_cnt - rd0, 0);
        CORE_IDLE = 1'b1;
        next(1);
        chk("e_c24_ia",   IA, 2);
        chk("e_c24_ien",  IEN, 1);
        next(2);
        chk("e_c26_insn", INSN, 8'h2E);

        // Asynchronous reset during a forward scan "+[++"
        load("+[++");
        CELL_ZERO = 1'b1;
        start();
        next(2);
        chk("f_c2_insn", INSN, 8'h2B);
        next(4);
        chk("f_c6_ia",  IA, 2);
        chk("f_c6_ien", IEN, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("f_rst_ien",   IEN, 0);
        chk("f_rst_ia",    IA, 0);
        chk("f_rst_insn",  INSN, 8'h00);
        chk("f_rst_valid", INSN_VALID, 0);
        chk("f_rst_halt",  HALT, 0);
        chk("f_rst_error", ERROR, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("f_rel_ia",  IA, 0);
        chk("f_rel_ien", IEN, 1);
        next(2);
        chk("f_rel_insn", INSN, 8'h2B);

        // PC wrap on normal increment
        for (int i = 0; i < 2048; i++) mem[i] = 8'h2B;
        mem[2047] = 8'h2E;
        start();
        guard = 0;
        while (guard < 7000 && !(IEN && IA == 11'd2047)) begin
            next(1);
            guard++;
        end
        chk("g_reach_top", (IEN && IA == 11'd2047), 1);
        next(2);
        chk("g_top_insn", INSN, 8'h2E);
        next(1);
        chk("g_wrap_ia",    IA, 0);
        chk("g_wrap_ien",   IEN, 1);
        chk("g_wrap_error", ERROR, 0);
        next(2);
        chk("g_wrap_insn", INSN, 8'h2B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iram_fetch_ctrl.md
IRAM_FETCH_CTRL -- requirements
Module: iram_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter IA_WIDTH, default 11, instruction address width.
REQ-002 The block SHALL have parameter DEPTH_WIDTH, default 8, bracket nesting counter width.
REQ-003 The block SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-004 The block SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port IA  output  IA_WIDTH  instruction RAM read address.
REQ-006 The block SHALL have port IEN  output  1  instruction RAM read enable.
REQ-007 The block SHALL have port IDIN  input  8  instruction RAM read data, valid the cycle after IEN=1.
REQ-008 The block SHALL have port INSN  output  8  instruction byte presented to core.
REQ-009 The block SHALL have port INSN_VALID  output  1  INSN valid.
REQ-010 The block SHALL have port INSN_READY  input  1  core accepts INSN.
REQ-011 The block SHALL have port CORE_IDLE  input  1  core has no instruction in flight; CELL_ZERO is current.
REQ-012 The block SHALL have port CELL_ZERO  input  1  current data cell equals 0.
REQ-013 The block SHALL have port HALT  output  1  program ended (0x00 fetched).
REQ-014 The block SHALL have port ERROR  output  1  unmatched bracket or nesting overflow.

Function
REQ-015 The block SHALL hold an IA_WIDTH-bit PC, a DEPTH_WIDTH-bit depth counter and states FETCH, DECODE, PRESENT, BR_WAIT, SCAN_FWD_RD, SCAN_FWD_DEC, SCAN_BK_RD, SCAN_BK_DEC, HALTED, ERR.
REQ-016 FETCH: IA=PC, IEN=1; next state DECODE; IEN SHALL be 0 in all non-read states.
REQ-017 DECODE: IDIN=0x00 -> HALTED; 0x5B or 0x5D -> BR_WAIT; otherwise INSN<=IDIN, -> PRESENT.
REQ-018 PRESENT: INSN_VALID=1, INSN held stable until INSN_READY=1; on acceptance PC<=PC+1 (modulo 2^IA_WIDTH), -> FETCH.
REQ-019 Latency: INSN_VALID SHALL rise two cycles after the FETCH cycle; accept at cycle k -> next INSN_VALID at k+3.
REQ-020 Brackets SHALL be consumed internally and never presented on INSN.
REQ-021 BR_WAIT SHALL hold until CORE_IDLE=1, then sample CELL_ZERO that cycle.
REQ-022 '[' with CELL_ZERO=0, or ']' with CELL_ZERO=1: PC<=PC+1, -> FETCH.
REQ-023 '[' with CELL_ZERO=1: depth<=1, PC<=PC+1, -> SCAN_FWD_RD; ']' with CELL_ZERO=0: depth<=1, PC<=PC-1, -> SCAN_BK_RD.
REQ-024 SCAN_*_RD SHALL issue IA=PC, IEN=1, then go to the matching *_DEC state (2 cycles per scanned byte).
REQ-025 SCAN_FWD_DEC: '[' depth+1; ']' depth-1; other bytes no change; if depth becomes 0 -> PC<=PC+1, FETCH; else PC<=PC+1, SCAN_FWD_RD.
REQ-026 SCAN_BK_DEC: ']' depth+1; '[' depth-1; if depth becomes 0 -> PC<=PC+1, FETCH (the matched '[' is not re-evaluated); else PC<=PC-1, SCAN_BK_RD.
REQ-027 ERR SHALL be entered when: 0x00 is read in forward scan; forward scan needs to advance from PC=2^IA_WIDTH-1; backward scan needs to retreat from PC=0; depth would overflow past all-ones.
REQ-028 HALTED and ERR SHALL be terminal until reset; HALT=1 or ERROR=1 respectively, INSN_VALID=0, IEN=0.
REQ-029 Normal (non-scan) PC increment SHALL wrap from 2^IA_WIDTH-1 to 0 without error.
REQ-030 INSN_READY while INSN_VALID=0 SHALL be ignored.

Reset
REQ-031 RST_N=0 SHALL immediately force state FETCH, PC=0, depth=0, INSN=0x00, INSN_VALID=0, HALT=0, ERROR=0, IEN=0.
REQ-032 Reset asserted mid-scan or mid-handshake SHALL abort the operation; first FETCH at PC=0 occurs on the first rising edge after RST_N=1.

Verification
REQ-033 RAM "+>" then 0x00, INSN_READY=1 -> INSN 0x2B at cycle 2, 0x3E at cycle 5, HALT=1 from cycle 7.
REQ-034 RAM "[+[-]>]." with CELL_ZERO=1, CORE_IDLE=1 -> scan skips to addr 7; first presented INSN is 0x2E; nested depth reached 2.
REQ-035 RAM "+[-]" ; CELL_ZERO=0 at ']' -> PC returns to 2, INSN 0x2D presented again; CELL_ZERO=1 -> proceeds to addr 4.
REQ-036 RAM "[+" then 0x00, CELL_ZERO=1 -> ERROR=1, INSN_VALID never asserted; RAM "+]" with CELL_ZERO=0 -> ERROR=1.
REQ-037 INSN_READY held 0 for 10 cycles -> INSN stable, PC unchanged; CORE_IDLE=0 at '[' -> BR_WAIT holds, no RAM reads.
REQ-038 RST_N pulsed low during SCAN_FWD_RD -> all outputs at reset values immediately; refetch from address 0 after release.
